// File: rtl/tri_bus_arbiter_pkg.sv
// Shared types and defaults for the tri-state bus arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
//
// Contents:
//   arb_state_t  - sequencer state encoding (IDLE / GRANT / TURN)
//   DEF_*        - default parameter values used by the top and sub-modules
package tri_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } arb_state_t;

  localparam int DEF_N_REQ      = 4;
  localparam int DEF_MAX_HOLD   = 16;
  localparam int DEF_TURNAROUND = 1;

endpackage

// File: rtl/tri_bus_arbiter_rr_pick.sv
// Round-robin winner selection: first requester at or after ptr, wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none; winner is valid whenever any req bit is set.
//
// Ports:
//   req        in   N_REQ  request vector
//   ptr        in   ID_W   highest-priority index for this search
//   win_onehot out  N_REQ  one-hot winner (zero when no request)
//   win_idx    out  ID_W   index of the winner (zero when no request)
//   win_vld    out  1      a winner exists
module rr_pick
  import tri_bus_arbiter_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] win_onehot,
  output logic [ID_W-1:0]  win_idx,
  output logic             win_vld
);

  localparam logic [ID_W-1:0] LAST_IDX = ID_W'(N_REQ - 1);

  // Walk N_REQ positions starting at ptr; the first set bit wins. The index
  // wraps explicitly so non-power-of-two N_REQ never visits an unused code.
  always_comb begin
    logic [ID_W-1:0] j;
    win_onehot = '0;
    win_idx    = '0;
    win_vld    = 1'b0;
    j          = ptr;
    for (int i = 0; i < N_REQ; i++) begin
      if (!win_vld && req[j]) begin
        win_vld       = 1'b1;
        win_onehot[j] = 1'b1;
        win_idx       = j;
      end
      j = (j == LAST_IDX) ? '0 : j + ID_W'(1);
    end
  end

endmodule

// File: rtl/tri_bus_arbiter.sv
// Round-robin owner sequencer for a shared tri-state bus with a forced all-off gap between owners.
// Latency: req sampled at an edge grants on that same edge (gnt visible the following cycle); release drops gnt in one edge.
// Backpressure: owners hold the bus until req drops / done strobes, or MAX_HOLD expires while others wait.
//
// Ports:
//   clk       in   1       rising-edge clock
//   rst       in   1       asynchronous active-high reset
//   req       in   N_REQ   level request per driver
//   done      in   N_REQ   release strobe; only the owner's bit is looked at
//   gnt       out  N_REQ   one-hot grant, zero when unowned
//   oe        out  N_REQ   tri enable per driver, identical to gnt
//   bus_busy  out  1       some driver owns the bus
//   owner_id  out  ID_W    current owner, or the last one while idle
//   preempt   out  1       pulses on the cycle an owner loses the bus to MAX_HOLD
module tri_bus_arbiter
  import tri_bus_arbiter_pkg::*;
#(
  parameter int N_REQ      = DEF_N_REQ,
  parameter int MAX_HOLD   = DEF_MAX_HOLD,
  parameter int TURNAROUND = DEF_TURNAROUND
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         done,
  output logic [N_REQ-1:0]         gnt,
  output logic [N_REQ-1:0]         oe,
  output logic                     bus_busy,
  output logic [$clog2(N_REQ)-1:0] owner_id,
  output logic                     preempt
);

  localparam int ID_W   = $clog2(N_REQ);
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam int TA_W   = $clog2(TURNAROUND + 1);

  localparam logic [ID_W-1:0]   LAST_IDX = ID_W'(N_REQ - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
  localparam logic [TA_W-1:0]   TA_LAST  = TA_W'(TURNAROUND);

  arb_state_t        state_q, state_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [ID_W-1:0]   owner_q, owner_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [TA_W-1:0]   ta_q, ta_d;
  logic              preempt_q, preempt_d;

  logic [N_REQ-1:0]  win_onehot;
  logic [ID_W-1:0]   win_idx;
  logic              win_vld;

  logic              owner_req;
  logic              owner_done;
  logic              others_req;
  logic              hold_full;
  logic [ID_W-1:0]   ptr_after;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req        (req),
    .ptr        (ptr_q),
    .win_onehot (win_onehot),
    .win_idx    (win_idx),
    .win_vld    (win_vld)
  );

  assign owner_req  = req[owner_q];
  assign owner_done = done[owner_q];
  // Anyone other than the owner waiting; non-owner done bits are ignored.
  assign others_req = |(req & ~gnt_q);
  assign hold_full  = (hold_q == HOLD_MAX);
  // Priority starts just past the outgoing owner so a preempted owner goes last.
  assign ptr_after  = (owner_q == LAST_IDX) ? '0 : owner_q + ID_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      hold_q    <= '0;
      ta_q      <= '0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      ta_q      <= ta_d;
      preempt_q <= preempt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    ta_d      = ta_q;
    preempt_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        gnt_d = '0;
        if (win_vld) begin
          state_d = ST_GRANT;
          gnt_d   = win_onehot;
          owner_d = win_idx;
          hold_d  = HOLD_W'(1);
        end
      end

      ST_GRANT: begin
        // A voluntary release wins over expiry, so no preempt in that case.
        if (!owner_req || owner_done) begin
          state_d = ST_TURN;
          gnt_d   = '0;
          ptr_d   = ptr_after;
          hold_d  = '0;
          ta_d    = TA_W'(1);
        end else if (hold_full && others_req) begin
          state_d   = ST_TURN;
          gnt_d     = '0;
          ptr_d     = ptr_after;
          hold_d    = '0;
          ta_d      = TA_W'(1);
          preempt_d = 1'b1;
        end else if (!hold_full) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end

      ST_TURN: begin
        gnt_d = '0;
        if (ta_q == TA_LAST) begin
          if (win_vld) begin
            state_d = ST_GRANT;
            gnt_d   = win_onehot;
            owner_d = win_idx;
            hold_d  = HOLD_W'(1);
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          ta_d = ta_q + TA_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  assign gnt      = gnt_q;
  assign oe       = gnt_q;
  assign bus_busy = |gnt_q;
  assign owner_id = owner_q;
  assign preempt  = preempt_q;

endmodule

// File: tb/tb_tri_bus_arbiter.sv
module tb_tri_bus_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] gnt;
  logic [3:0] oe;
  logic       bus_busy;
  logic [1:0] owner_id;
  logic       preempt;

  int total;
  int bad;

  int exp_q[$];    // expected owner sequence, pushed with stimulus
  int len_log[$];  // observed ownership lengths in cycles
  int gap_log[$];  // observed all-zero cycles before each new owner

  logic [3:0] prev_gnt;
  int cur_len;
  int gap;
  int grants;
  int preempt_cnt;

  tri_bus_arbiter #(
    .N_REQ      (4),
    .MAX_HOLD   (16),
    .TURNAROUND (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .done     (done),
    .gnt      (gnt),
    .oe       (oe),
    .bus_busy (bus_busy),
    .owner_id (owner_id),
    .preempt  (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to the next falling edge and observe: invariants, scoreboard pop
  // on each new owner, ownership length and gap bookkeeping.
  task automatic step();
    int e;
    logic [3:0] eg;
    @(negedge clk);
    total++;
    if (((gnt & (gnt - 4'd1)) != 4'd0) || (oe !== gnt) || (bus_busy !== (|gnt))) begin
      bad++;
      $display("FAIL invariant: gnt=%b oe=%b busy=%b", gnt, oe, bus_busy);
    end
    if (preempt === 1'b1) begin
      preempt_cnt++;
      total++;
      if (!(prev_gnt != 4'd0 && gnt == 4'd0)) begin
        bad++;
        $display("FAIL preempt_timing: gnt=%b prev=%b want drop cycle", gnt, prev_gnt);
      end
    end
    if (gnt != 4'd0 && gnt != prev_gnt) begin
      total++;
      if (prev_gnt != 4'd0) begin
        bad++;
        $display("FAIL handover_gap: got %b -> %b want zero cycle between", prev_gnt, gnt);
      end
      gap_log.push_back(gap);
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_grant: got owner %0d want none", owner_id);
      end else begin
        e  = exp_q.pop_front();
        eg = 4'b0001 << e;
        if (owner_id !== 2'(e) || gnt !== eg) begin
          bad++;
          $display("FAIL grant_order: got id=%0d gnt=%b want id=%0d gnt=%b", owner_id, gnt, e, eg);
        end
      end
      cur_len = 0;
      grants++;
    end
    if (gnt == 4'd0 && prev_gnt != 4'd0) begin
      len_log.push_back(cur_len);
      gap = 0;
    end
    if (gnt != 4'd0) cur_len++;
    else gap++;
    prev_gnt = gnt;
  endtask

  // Run until n new owners have been granted. Each owner strobes done on its
  // done_at-th cycle (0 = never); the n-th owner drops req after last_len cycles.
  task automatic run_owners(input int n, input int done_at, input int last_len);
    int g0;
    bit fin;
    g0  = grants;
    fin = 1'b0;
    for (int i = 0; i < 300 && !fin; i++) begin
      step();
      done = '0;
      if (gnt != 4'd0) begin
        if ((grants - g0) == n && cur_len == last_len) begin
          req = '0;
          fin = 1'b1;
        end else if (done_at > 0 && cur_len == done_at) begin
          done = gnt;
        end
      end
    end
    done = '0;
    total++;
    if (!fin) begin
      bad++;
      $display("FAIL run_timeout: got grants=%0d want %0d", grants - g0, n);
    end
    for (int k = 0; k < 2; k++) begin
      step();
      total++;
      if (gnt !== 4'd0) begin
        bad++;
        $display("FAIL release_idle: got gnt=%b want 0000", gnt);
      end
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL missing_grants: got %0d left want 0", exp_q.size());
    end
  endtask

  task automatic check_lens(input string name, input int n, input int l0, input int l1, input int l2, input int l3);
    int want[4];
    want = '{l0, l1, l2, l3};
    for (int i = 0; i < n; i++) begin
      total++;
      if (i >= len_log.size() || len_log[i] != want[i]) begin
        bad++;
        $display("FAIL %s_len%0d: got %0d want %0d", name, i,
                 (i < len_log.size()) ? len_log[i] : -1, want[i]);
      end
    end
  endtask

  task automatic check_gaps(input string name, input int n);
    // gap_log[0] follows an idle period; later entries are owner-to-owner gaps.
    for (int i = 1; i < n; i++) begin
      total++;
      if (i >= gap_log.size() || gap_log[i] != 1) begin
        bad++;
        $display("FAIL %s_gap%0d: got %0d want 1", name, i,
                 (i < gap_log.size()) ? gap_log[i] : -1);
      end
    end
  endtask

  task automatic clear_logs();
    len_log.delete();
    gap_log.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    done = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '0;
    done = '0;
    repeat (2) @(negedge clk);
    total += 5;
    if (gnt !== 4'd0)      begin bad++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    if (oe !== 4'd0)       begin bad++; $display("FAIL reset_oe: got %b want 0000", oe); end
    if (bus_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus_busy); end
    if (owner_id !== 2'd0) begin bad++; $display("FAIL reset_owner: got %0d want 0", owner_id); end
    if (preempt !== 1'b0)  begin bad++; $display("FAIL reset_preempt: got %b want 0", preempt); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    exp_q.push_back(1);
    req = 4'b0010;
    step();
    total++;
    if (gnt !== 4'b0010 || owner_id !== 2'd1) begin
      bad++;
      $display("FAIL single_grant: got gnt=%b id=%0d want 0010 id=1", gnt, owner_id);
    end
    step();
    step();
    total++;
    if (gnt !== 4'b0010) begin bad++; $display("FAIL single_hold: got %b want 0010", gnt); end
    req = '0;
    for (int k = 0; k < 2; k++) begin
      step();
      total++;
      if (gnt !== 4'd0) begin bad++; $display("FAIL single_release: got %b want 0000", gnt); end
    end
  endtask

  task automatic test_contention();
    int p0;
    do_reset();
    clear_logs();
    p0 = preempt_cnt;
    exp_q = '{0, 1, 2, 3};
    req = 4'b1111;
    run_owners(4, 3, 3);
    check_lens("contention", 4, 3, 3, 3, 3);
    check_gaps("contention", 4);
    total++;
    if (preempt_cnt != p0) begin bad++; $display("FAIL contention_preempt: got %0d want 0", preempt_cnt - p0); end
  endtask

  task automatic test_preempt();
    int p0;
    clear_logs();
    p0 = preempt_cnt;
    exp_q = '{0, 2, 0};
    req = 4'b0101;
    run_owners(3, 0, 4);
    check_lens("preempt", 3, 16, 16, 4, 0);
    check_gaps("preempt", 3);
    total++;
    if (preempt_cnt - p0 != 2) begin bad++; $display("FAIL preempt_count: got %0d want 2", preempt_cnt - p0); end
  endtask

  task automatic test_alone();
    int p0;
    clear_logs();
    p0 = preempt_cnt;
    exp_q = '{3};
    req = 4'b1000;
    run_owners(1, 0, 40);
    check_lens("alone", 1, 40, 0, 0, 0);
    total++;
    if (preempt_cnt != p0) begin bad++; $display("FAIL alone_preempt: got %0d want 0", preempt_cnt - p0); end
  endtask

  task automatic test_release_at_expiry();
    int p0;
    clear_logs();
    p0 = preempt_cnt;
    exp_q = '{0, 1};
    req = 4'b0011;
    run_owners(2, 16, 2);
    check_lens("expiry", 2, 16, 2, 0, 0);
    check_gaps("expiry", 2);
    total++;
    if (preempt_cnt != p0) begin bad++; $display("FAIL expiry_preempt: got %0d want 0", preempt_cnt - p0); end
  endtask

  task automatic test_async_reset();
    exp_q = '{2};
    req = 4'b0100;
    step();
    total++;
    if (gnt !== 4'b0100) begin bad++; $display("FAIL areset_pre: got %b want 0100", gnt); end
    #2;
    rst = 1'b1;
    #1;
    total += 2;
    if (gnt !== 4'd0 || oe !== 4'd0) begin
      bad++;
      $display("FAIL areset_immediate: got gnt=%b oe=%b want 0000", gnt, oe);
    end
    if (bus_busy !== 1'b0) begin bad++; $display("FAIL areset_busy: got %b want 0", bus_busy); end
    step();
    rst = 1'b0;
    clear_logs();
    exp_q = '{0};
    req = 4'b1111;
    run_owners(1, 0, 2);
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    prev_gnt    = '0;
    cur_len     = 0;
    gap         = 1000;
    grants      = 0;
    preempt_cnt = 0;
    rst         = 1'b1;
    req         = '0;
    done        = '0;

    test_reset();
    test_single();
    test_contention();
    test_preempt();
    test_alone();
    test_release_at_expiry();
    test_async_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
